// File: rtl/tiny_cpu_pkg.sv
// Shared types and constants for the tiny CPU front end.
package tiny_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_WIDTH = 16;
    localparam int unsigned BYTE_WIDTH  = 8;
    localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 16'h0000;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetches 16-bit instructions as two bytes (high first) over a req/ack byte bus
// and owns the program counter, including jump redirect mid-fetch.
module instruction_fetch_unit
    import tiny_cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk_in,
    input  logic                   reset_n_in,
    input  logic                   fetch_start_in,
    input  logic                   jump_en_in,
    input  logic [ADDR_WIDTH-1:0]  jump_addr_in,
    output logic                   mem_req_out,
    output logic [ADDR_WIDTH-1:0]  mem_addr_out,
    input  logic                   mem_ack_in,
    input  logic [BYTE_WIDTH-1:0]  mem_rdata_in,
    output logic                   ir_write_en_out,
    output logic [INSTR_WIDTH-1:0] ir_data_out,
    output logic [ADDR_WIDTH-1:0]  pc_out
    ,
    output logic                   busy_out
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [BYTE_WIDTH-1:0] hi_byte;
    logic                  jump_pending;

    logic [ADDR_WIDTH-1:0] jump_tgt_c;
    logic                  discard_c;

    // Instructions are halfword aligned, so bit 0 of a jump target is dropped.
    assign jump_tgt_c = jump_addr_in & ~ADDR_WIDTH'(1);
    // A jump seen earlier in this fetch, or arriving now, kills the fetch.
    assign discard_c  = jump_pending | jump_en_in;
    assign pc_out     = pc;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            hi_byte         <= '0;
            jump_pending    <= 1'b0;
            mem_req_out     <= 1'b0;
            mem_addr_out    <= '0;
            ir_write_en_out <= 1'b0;
            ir_data_out     <= INSTR_NOP;
            busy_out        <= 1'b0;
        end else begin
            ir_write_en_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (jump_en_in) begin
                        pc <= jump_tgt_c;
                    end
                    if (fetch_start_in) begin
                        mem_req_out  <= 1'b1;
                        mem_addr_out <= jump_en_in ? jump_tgt_c : pc;
                        busy_out     <= 1'b1;
                        state        <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (jump_en_in) begin
                        pc           <= jump_tgt_c;
                        jump_pending <= 1'b1;
                    end
                    if (mem_ack_in) begin
                        if (discard_c) begin
                            // Let the outstanding byte finish, skip the low byte.
                            mem_req_out  <= 1'b0;
                            busy_out     <= 1'b0;
                            jump_pending <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            hi_byte      <= mem_rdata_in;
                            mem_addr_out <= pc | ADDR_WIDTH'(1);
                            state        <= REQ_LO;
                        end
                    end
                end
                REQ_LO: begin
                    if (jump_en_in) begin
                        pc           <= jump_tgt_c;
                        jump_pending <= 1'b1;
                    end
                    if (mem_ack_in) begin
                        mem_req_out  <= 1'b0;
                        busy_out     <= 1'b0;
                        jump_pending <= 1'b0;
                        state        <= IDLE;
                        if (!discard_c) begin
                            ir_data_out     <= {hi_byte, mem_rdata_in};
                            ir_write_en_out <= 1'b1;
                            pc              <= pc + ADDR_WIDTH'(2);
                        end
                    end
                end
                default: begin
                    mem_req_out <= 1'b0;
                    busy_out    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a byte memory model and
// programmable ack wait states.
module tb_instruction_fetch_unit;

    logic        clk_in;
    logic        reset_n_in;
    logic        fetch_start_in;
    logic        jump_en_in;
    logic [15:0] jump_addr_in;
    logic        mem_req_out;
    logic [15:0] mem_addr_out;
    logic        mem_ack_in;
    logic [7:0]  mem_rdata_in;
    logic        ir_write_en_out;
    logic [15:0] ir_data_out;
    logic [15:0] pc_out;
    logic        busy_out;

    logic [7:0]  mem [0:65535];
    int          hi_wait;
    int          lo_wait;
    logic        hold_ack;
    int          wait_cnt;
    int          strobe_cnt;
    int          n_checks;
    int          n_fail;

    instruction_fetch_unit #(
        .ADDR_WIDTH (16),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk_in          (clk_in),
        .reset_n_in      (reset_n_in),
        .fetch_start_in  (fetch_start_in),
        .jump_en_in      (jump_en_in),
        .jump_addr_in    (jump_addr_in),
        .mem_req_out     (mem_req_out),
        .mem_addr_out    (mem_addr_out),
        .mem_ack_in      (mem_ack_in),
        .mem_rdata_in    (mem_rdata_in),
        .ir_write_en_out (ir_write_en_out),
        .ir_data_out     (ir_data_out),
        .pc_out          (pc_out),
        .busy_out        (busy_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Memory model: ack after a per-byte number of wait cycles.
    assign mem_rdata_in = mem[mem_addr_out];
    assign mem_ack_in   = mem_req_out && !hold_ack &&
                          (wait_cnt >= (mem_addr_out[0] ? lo_wait : hi_wait));

    always @(posedge clk_in) begin
        if (mem_req_out && !mem_ack_in) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
        if (ir_write_en_out) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one fetch from the current negedge and follow it to its strobe.
    task automatic fetch(input string tag, input logic jmp, input logic [15:0] jaddr,
                         input logic [15:0] exp_addr, input logic [15:0] exp_data,
                         input logic [15:0] exp_pc, input int exp_lat, input logic hold_start);
        int   lat;
        int   s0;
        logic got;
        s0 = strobe_cnt;
        fetch_start_in = 1'b1;
        jump_en_in     = jmp;
        jump_addr_in   = jaddr;
        @(negedge clk_in);
        jump_en_in = 1'b0;
        if (!hold_start) fetch_start_in = 1'b0;
        check({tag, "_hi_addr"}, 32'(mem_addr_out), 32'(exp_addr));
        lat = 1;
        got = 1'b0;
        while (lat < 40 && !got) begin
            if (lat == 3) fetch_start_in = 1'b0;
            check({tag, "_req_held"}, 32'(mem_req_out), 32'd1);
            check({tag, "_addr_ok"},
                  32'((mem_addr_out == exp_addr) || (mem_addr_out == (exp_addr | 16'h0001))), 32'd1);
            @(negedge clk_in);
            lat++;
            got = ir_write_en_out;
        end
        fetch_start_in = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(ir_data_out), 32'(exp_data));
        check({tag, "_pc"}, 32'(pc_out), 32'(exp_pc));
        check({tag, "_req_done"}, 32'(mem_req_out), 32'd0);
        @(negedge clk_in);
        check({tag, "_we_pulse"}, 32'(ir_write_en_out), 32'd0);
        check({tag, "_data_hold"}, 32'(ir_data_out), 32'(exp_data));
        check({tag, "_one_strobe"}, 32'(strobe_cnt - s0), 32'd1);
        check({tag, "_idle"}, 32'(busy_out), 32'd0);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        strobe_cnt     = 0;
        wait_cnt       = 0;
        hi_wait        = 0;
        lo_wait        = 0;
        hold_ack       = 1'b0;
        fetch_start_in = 1'b0;
        jump_en_in     = 1'b0;
        jump_addr_in   = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'h12; mem[16'h0001] = 8'h34;
        mem[16'h0002] = 8'h56; mem[16'h0003] = 8'h78;
        mem[16'hFFFE] = 8'hAB; mem[16'hFFFF] = 8'hCD;
        mem[16'h0100] = 8'h9A; mem[16'h0101] = 8'hBC;
        mem[16'h0040] = 8'hDE; mem[16'h0041] = 8'hAD;
        mem[16'h0080] = 8'hC3; mem[16'h0081] = 8'h3C;

        reset_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check("rst_req", 32'(mem_req_out), 32'd0);
        check("rst_addr", 32'(mem_addr_out), 32'd0);
        check("rst_we", 32'(ir_write_en_out), 32'd0);
        check("rst_data", 32'(ir_data_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_pc", 32'(pc_out), 32'd0);
        reset_n_in = 1'b1;
        @(negedge clk_in);

        // Zero-wait fetch, then waits of 3/2 with start held while busy.
        fetch("t1", 1'b0, 16'h0, 16'h0000, 16'h1234, 16'h0002, 3, 1'b0);
        hi_wait = 3; lo_wait = 2;
        fetch("t2", 1'b0, 16'h0, 16'h0002, 16'h5678, 16'h0004, 8, 1'b1);
        hi_wait = 0; lo_wait = 0;

        // Jump alone in IDLE to an odd address, then fetch across the wrap.
        jump_en_in = 1'b1; jump_addr_in = 16'hFFFF;
        @(negedge clk_in);
        jump_en_in = 1'b0;
        check("t3_jump_pc", 32'(pc_out), 32'h0000FFFE);
        check("t3_jump_idle", 32'(busy_out), 32'd0);
        fetch("t3", 1'b0, 16'h0, 16'hFFFE, 16'hABCD, 16'h0000, 3, 1'b0);

        fetch("t4", 1'b1, 16'h0101, 16'h0100, 16'h9ABC, 16'h0102, 3, 1'b0);

        // Jump during REQ_HI with ack withheld.
        hold_ack = 1'b1;
        fetch_start_in = 1'b1;
        @(negedge clk_in);
        fetch_start_in = 1'b0;
        jump_en_in = 1'b1; jump_addr_in = 16'h0040;
        @(negedge clk_in);
        jump_en_in = 1'b0;
        check("t5_pc", 32'(pc_out), 32'h00000040);
        check("t5_req", 32'(mem_req_out), 32'd1);
        check("t5_addr", 32'(mem_addr_out), 32'h00000102);
        @(negedge clk_in);
        check("t5_req_wait", 32'(mem_req_out), 32'd1);
        check("t5_addr_wait", 32'(mem_addr_out), 32'h00000102);
        hold_ack = 1'b0;
        @(negedge clk_in);
        check("t5_req_drop", 32'(mem_req_out), 32'd0);
        check("t5_busy", 32'(busy_out), 32'd0);
        check("t5_no_we", 32'(ir_write_en_out), 32'd0);
        check("t5_pc_after", 32'(pc_out), 32'h00000040);
        check("t5_strobes", 32'(strobe_cnt), 32'd4);
        fetch("t5b", 1'b0, 16'h0, 16'h0040, 16'hDEAD, 16'h0042, 3, 1'b0);

        // Jump arriving on the same cycle as the low-byte ack.
        fetch_start_in = 1'b1;
        @(negedge clk_in);
        fetch_start_in = 1'b0;
        @(negedge clk_in);
        jump_en_in = 1'b1; jump_addr_in = 16'h0080;
        @(negedge clk_in);
        jump_en_in = 1'b0;
        check("t6_no_we", 32'(ir_write_en_out), 32'd0);
        check("t6_pc", 32'(pc_out), 32'h00000080);
        check("t6_busy", 32'(busy_out), 32'd0);
        check("t6_data_hold", 32'(ir_data_out), 32'h0000DEAD);
        fetch("t6b", 1'b0, 16'h0, 16'h0080, 16'hC33C, 16'h0082, 3, 1'b0);

        // Asynchronous reset while the low-byte request is outstanding.
        lo_wait = 10;
        fetch_start_in = 1'b1;
        @(negedge clk_in);
        fetch_start_in = 1'b0;
        @(negedge clk_in);
        check("t7_req_lo", 32'(mem_req_out), 32'd1);
        check("t7_addr_lo", 32'(mem_addr_out), 32'h00000083);
        #2 reset_n_in = 1'b0;
        #1;
        check("t7_rst_req", 32'(mem_req_out), 32'd0);
        check("t7_rst_busy", 32'(busy_out), 32'd0);
        check("t7_rst_pc", 32'(pc_out), 32'd0);
        check("t7_rst_data", 32'(ir_data_out), 32'd0);
        @(negedge clk_in);
        reset_n_in = 1'b1;
        lo_wait = 0;
        @(negedge clk_in);
        check("t7_strobes", 32'(strobe_cnt), 32'd6);
        fetch("t7b", 1'b0, 16'h0, 16'h0000, 16'h1234, 16'h0002, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetches 16-bit instructions from a byte-wide instruction memory using a req/ack handshake.
- Assembles two bytes, high byte first, into one instruction word.
- Delivers the word to the instruction register as a one-cycle write strobe plus data.
- Owns the program counter: sequential increment, plus redirect on jump. Sits between the core sequencer and the memory/bus interface.

Parameters:
- ADDR_WIDTH, 16, byte-address width of PC and memory bus.
- RESET_PC, 0, PC value after reset; must be even.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge.
- reset_n_in  input  1  asynchronous active-low reset.
- fetch_start_in  input  1  core requests the next instruction; sampled in IDLE only.
- jump_en_in  input  1  load PC from jump_addr_in.
- jump_addr_in  input  ADDR_WIDTH  jump target; bit 0 ignored and forced to 0.
- mem_req_out  output  1  memory read request, registered.
- mem_addr_out  output  ADDR_WIDTH  byte address of current request, registered.
- mem_ack_in  input  1  memory read data valid; meaningful only while mem_req_out=1.
- mem_rdata_in  input  8  read byte, valid when mem_ack_in=1.
- ir_write_en_out  output  1  one-cycle strobe: ir_data_out holds a new instruction.
- ir_data_out  output  16  assembled instruction, {byte@pc, byte@pc+1}.
- pc_out  output  ADDR_WIDTH  address of the next instruction to fetch.
- busy_out  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE, pc=RESET_PC
  - mem_req_out=0, mem_addr_out=0
  - ir_write_en_out=0, ir_data_out=16'h0000
  - busy_out=0, jump_pending=0
- States: IDLE, REQ_HI, REQ_LO.
- IDLE:
  - fetch_start_in=1 -> REQ_HI. mem_req_out=1, mem_addr_out=pc.
  - jump_en_in=1 -> pc <= {jump_addr_in[ADDR_WIDTH-1:1],1'b0}.
  - Both asserted in the same cycle: fetch uses the jump target as its address.
- REQ_HI:
  - Hold mem_req_out=1 and mem_addr_out stable until mem_ack_in=1.
  - On ack: capture mem_rdata_in into hi byte; mem_addr_out <= pc+1; go to REQ_LO.
- REQ_LO:
  - Hold until ack.
  - On ack: mem_req_out <= 0; ir_data_out <= {hi, mem_rdata_in}; ir_write_en_out <= 1 for exactly one cycle; pc <= pc+2; go to IDLE.
- Latency:
  - Start sampled at cycle N -> mem_req_out high at N+1.
  - With zero-wait ack (ack in the same cycle as req), ir_write_en_out is high at N+3.
  - Each wait cycle on either byte adds one cycle.
- ir_data_out holds its last value between strobes. Only ir_write_en_out pulses.
- PC arithmetic is modulo 2^ADDR_WIDTH:
  - pc=0xFFFE fetches bytes 0xFFFE and 0xFFFF, then pc wraps to 0x0000.
  - The lo-byte address pc+1 never carries, since pc is always even.
- fetch_start_in while busy: ignored, not queued.
- Jump while busy (REQ_HI or REQ_LO):
  - pc <= aligned target; set jump_pending.
  - The outstanding memory transaction still completes; req is never dropped before ack.
  - Data from the aborted fetch is discarded, and the remaining byte is not requested.
  - On completion: no ir_write_en_out, no pc+2, return to IDLE, clear jump_pending.
  - A jump arriving on the same cycle as the lo-byte ack is handled the same way: the fetch is discarded.
- A later jump while jump_pending=1 overwrites pc (last jump wins).
- Reset mid-fetch: mem_req_out drops immediately. The memory side must tolerate an abandoned request.
- No instruction decoding here. Skip and halt squashing belong to the instruction register downstream.

Decomposition:
- Shared package tiny_cpu_pkg holds:
  - enum fetch_state_t {IDLE, REQ_HI, REQ_LO}
  - localparam INSTR_WIDTH=16
  - localparam INSTR_NOP=16'h0000
- A single flat module. No sub-module is natural; datapath is the PC register, hi-byte register and output registers.

Test Plan:
- Reset with RESET_PC=0, memory[0..1]=0x12,0x34, zero-wait ack; pulse start -> mem_addr 0x0000 then 0x0001; ir_write_en one cycle at N+3 with ir_data=0x1234; pc_out=0x0002.
- Ack delayed 3 cycles on hi byte and 2 on lo byte -> mem_addr and req stable throughout wait; strobe at N+8; single strobe only.
- pc=0xFFFE, memory 0xAB,0xCD -> ir_data=0xABCD; pc_out=0x0000.
- Start and jump_en with jump_addr=0x0101 in the same IDLE cycle -> fetch addresses 0x0100, 0x0101; pc_out=0x0102 after strobe.
- Jump to 0x0040 while in REQ_HI with ack withheld -> req held until ack; no strobe; pc_out=0x0040; next start fetches 0x0040/0x0041.
- reset_n_in low while mem_req_out=1 in REQ_LO -> mem_req_out=0 and busy_out=0 without a clock edge; pc_out=RESET_PC; fetch_start_in during busy ignored (no second strobe).
